// File: rtl/vthernet_pkg.sv
// Shared Vthernet MAC definitions: TX state encoding, framing constants,
// GMII output bundle and the bit-serial reflected CRC-32 byte step.
package vthernet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [10:0] MIN_FRAME     = 11'd60;
  localparam logic [10:0] FCS_LEN       = 11'd4;
  localparam logic [10:0] PRE_LEN       = 11'd7;
  localparam logic [10:0] MAX_LEN       = 11'd1024;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
  } gmii_tx_t;

  // One byte of LSB-first CRC-32, data bit 0 enters first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 accumulator (IEEE 802.3). Shared by the TX FCS generator
// and the RX FCS checker. crc holds the raw register; callers complement it.
module crc32_d8
  import vthernet_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // Clear wins over enable so a new frame can start on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/gmii_tx_engine.sv
// Vthernet MAC transmit engine: TX SRAM -> GMII (preamble, SFD, data, pad,
// FCS, IFG). Define GMII_TX_FCS_EN to generate pad and FCS in hardware;
// otherwise the frame is sent exactly as stored.
module gmii_tx_engine
  import vthernet_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int IFG_CYCLES = 12
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              tx_start,
  input  logic [10:0]       tx_len,
  output logic              mem_csb,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dout,
  output logic [7:0]        TXD,
  output logic              TX_EN,
  output logic              TX_ER,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

  tx_state_t         state, state_nxt;
  logic [10:0]       cnt, cnt_nxt, len_q, last_idx, rd_idx;
  logic              start_ok;
  gmii_tx_t          tx_q, tx_nxt;
  logic              busy_nxt, done_nxt, csb_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  assign start_ok = tx_start && (tx_len != 11'd0) && (tx_len <= MAX_LEN);
  assign last_idx = len_q - 11'd1;
  // Reads run two bytes ahead of the byte on TXD (SRAM latency + TXD register).
  assign rd_idx   = cnt_nxt + 11'd2;
  assign TXD      = tx_q.txd;
  assign TX_EN    = tx_q.en;
  assign TX_ER    = 1'b0;

`ifdef GMII_TX_FCS_EN
  logic        crc_clr, crc_en;
  logic [31:0] crc, crc_inv;
  assign crc_inv = ~crc;

  crc32_d8 u_crc (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (tx_nxt.txd),
    .crc  (crc)
  );
`endif

  // State register; every output is registered from its next-cycle value.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      len_q    <= '0;
      tx_q     <= '0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      mem_csb  <= 1'b1;
      mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (state == ST_IDLE && start_ok) len_q <= tx_len;
      tx_q     <= tx_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
      mem_csb  <= csb_nxt;
      mem_addr <= addr_nxt;
    end
  end

  // Next state: cnt is the byte index within the current state, except that
  // PAD keeps counting from DATA so it measures bytes since the SFD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 11'd1;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start_ok) state_nxt = ST_PRE;
      end
      ST_PRE:  if (cnt == PRE_LEN - 11'd1) begin state_nxt = ST_SFD; cnt_nxt = '0; end
      ST_SFD:  begin state_nxt = ST_DATA; cnt_nxt = '0; end
      ST_DATA: if (cnt == last_idx) begin
`ifdef GMII_TX_FCS_EN
        if (len_q < MIN_FRAME) state_nxt = ST_PAD;
        else begin state_nxt = ST_FCS; cnt_nxt = '0; end
`else
        state_nxt = ST_IFG; cnt_nxt = '0;
`endif
      end
`ifdef GMII_TX_FCS_EN
      ST_PAD:  if (cnt == MIN_FRAME - 11'd1) begin state_nxt = ST_FCS; cnt_nxt = '0; end
      ST_FCS:  if (cnt == FCS_LEN - 11'd1) begin state_nxt = ST_IFG; cnt_nxt = '0; end
`endif
      ST_IFG:  if (cnt == IFG_LAST) begin state_nxt = ST_IDLE; cnt_nxt = '0; end
      default: begin state_nxt = ST_IDLE; cnt_nxt = '0; end
    endcase
  end

  // Outputs for the coming cycle, decoded from the next state and count.
  always_comb begin
    tx_nxt   = '0;
    csb_nxt  = 1'b1;
    addr_nxt = mem_addr;
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_IFG) && (cnt_nxt == IFG_LAST);
`ifdef GMII_TX_FCS_EN
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
`endif
    case (state_nxt)
      ST_PRE: begin
        tx_nxt = '{txd: PREAMBLE_BYTE, en: 1'b1};
`ifdef GMII_TX_FCS_EN
        crc_clr = 1'b1;
`endif
        if (cnt_nxt == PRE_LEN - 11'd1) begin csb_nxt = 1'b0; addr_nxt = '0; end
      end
      ST_SFD: begin
        tx_nxt = '{txd: SFD_BYTE, en: 1'b1};
        if (len_q > 11'd1) begin csb_nxt = 1'b0; addr_nxt = ADDR_W'(1); end
      end
      ST_DATA: begin
        tx_nxt = '{txd: mem_dout, en: 1'b1};
`ifdef GMII_TX_FCS_EN
        crc_en = 1'b1;
`endif
        if (rd_idx <= last_idx) begin csb_nxt = 1'b0; addr_nxt = rd_idx[ADDR_W-1:0]; end
      end
`ifdef GMII_TX_FCS_EN
      ST_PAD: begin
        tx_nxt = '{txd: 8'h00, en: 1'b1};
        crc_en = 1'b1;
      end
      ST_FCS: tx_nxt = '{txd: crc_inv[{cnt_nxt[1:0], 3'b000} +: 8], en: 1'b1};
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/gmii_tx_engine.md
# gmii_tx_engine

Transmit half of the Vthernet MAC. It reads a frame that firmware has written into the TX SRAM through Wishbone and serialises it onto the GMII transmit pins: preamble, SFD, payload, zero padding and FCS, followed by the inter-frame gap. It mirrors the receive path, which fills the RX SRAM from the GMII receive pins. It sits inside the MAC between the Wishbone register block (start/length/done) and the TX SRAM read port.

## Interface
Parameters:
- `ADDR_W`, default 10: TX SRAM address width (1024 bytes).
- `IFG_CYCLES`, default 12: number of idle cycles after each frame.

Ports:
- `wb_clk_i` input 1: single clock, 125 MHz GMII TX clock. It is also forwarded to `GTX_CLK` outside this block.
- `wb_rst_i` input 1: asynchronous, active-high reset.
- `tx_start` input 1: one-cycle request to send a frame. It is sampled only in IDLE.
- `tx_len` input 11: frame length in bytes, from destination MAC through the end of payload, excluding FCS. Valid range is 1..1024. It is latched on an accepted start.
- `mem_csb` output 1: active-low chip select of the TX SRAM read port.
- `mem_addr` output ADDR_W: TX SRAM byte address.
- `mem_dout` input 8: TX SRAM read data. It is valid the cycle after address and chip select are presented.
- `TXD` output 8: GMII transmit data.
- `TX_EN` output 1: GMII transmit enable.
- `TX_ER` output 1: GMII transmit error. It is constant 0.
- `tx_busy` output 1: high from an accepted start until the IFG completes.
- `tx_done` output 1: one-cycle pulse in the last IFG cycle.

## Operation
- States are IDLE → PRE → SFD → DATA → PAD → FCS → IFG → IDLE.
- IDLE: a start with `tx_len` in 1..1024 is accepted. A start with `tx_len`=0 or `tx_len`>1024 is ignored: no busy, no done.
- PRE: 7 bytes of 0x55.
- SFD: 1 byte of 0xD5.
- DATA: bytes 0..len-1, read from TX SRAM addresses 0..len-1 in order.
- PAD: 0x00 bytes until 60 bytes have been sent after the SFD. PAD is skipped when len ≥ 60.
- FCS: 4 bytes, sent LSB first.
- IFG: `IFG_CYCLES` cycles with TX_EN=0 and TXD=0x00.
- The byte counter and CRC are cleared on entry to PRE.
- CRC-32 (IEEE 802.3) covers DATA and PAD bytes only:
  - reflected polynomial 0xEDB88320;
  - initial value 0xFFFFFFFF;
  - transmitted value is the bitwise complement of the register, low byte first.
- `tx_start` while busy is ignored. It is neither queued nor does it abort the current frame.
- `tx_len` changes after acceptance have no effect.
- `mem_csb`=1 whenever no read is needed; `mem_addr` holds its last value when idle.
- Reset mid-frame aborts immediately: no FCS, no IFG, and the state returns to IDLE.

## Timing
- Reset values:
  - TXD=0x00, TX_EN=0, TX_ER=0;
  - tx_busy=0, tx_done=0;
  - mem_csb=1, mem_addr=0;
  - state IDLE.
- TXD, TX_EN, tx_busy, tx_done, mem_csb and mem_addr are all registered.
- Cycle numbering is relative to the accepted start, which is sampled at the edge ending cycle 0:
  - cycles 1..7: TX_EN=1, TXD=0x55;
  - cycle 8: TXD=0xD5;
  - cycle 9+k: data byte k.
- Prefetch: address k is presented with mem_csb=0 in cycle 7+k. The data arrives in cycle 8+k and is registered onto TXD for cycle 9+k.
- Let N = max(len, 60). The FCS occupies cycles 9+N..12+N.
- TX_EN falls in cycle 13+N. IFG covers cycles 13+N..12+N+IFG_CYCLES.
- tx_done is high in cycle 12+N+IFG_CYCLES. tx_busy is high from cycle 1 through that cycle.
- The earliest next start is accepted in the cycle after tx_done.

## Configuration
- With `GMII_TX_FCS_EN` defined: PAD and FCS are generated as described above, and crc32_d8 is instantiated.
- Without it:
  - no padding and no FCS; the frame is sent exactly as stored, and firmware supplies the pad and FCS;
  - TX_EN falls in cycle 9+len;
  - the valid `tx_len` range is unchanged;
  - no CRC logic is synthesised.

## Structure
- The shared package `vthernet_pkg` holds:
  - state enum;
  - PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5;
  - MIN_FRAME=60, FCS_LEN=4, PRE_LEN=7;
  - CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF.
- Sub-module `crc32_d8`: byte-wide combinational next-CRC plus its state register, with clear and enable inputs. The same module is reusable by the RX FCS checker.

## Test plan
- 64-byte frame, SRAM[k]=k: TX_EN high for exactly 76 cycles. The sequence is 7×0x55, 0xD5, 0x00..0x3F, then an FCS equal to the bench model's CRC-32 of those bytes. tx_done occurs 12 cycles after TX_EN falls.
- 14-byte frame: 14 data bytes, then 46×0x00, then FCS over all 60 bytes. TX_EN is high for 72 cycles.
- crc32_d8 unit test: feeding ASCII "123456789" gives a complemented result of 0xCBF43926.
- tx_len=0 and tx_len=1025: no TX_EN, no busy, no done. A following valid start works normally.
- tx_start pulsed during DATA, and again on the tx_done cycle: both ignored, only one frame sent. A start in the cycle after tx_done is accepted.
- wb_rst_i asserted asynchronously at data byte 20: TX_EN=0 and mem_csb=1 without waiting for a clock edge, and no FCS bytes appear. After release, a 60-byte frame transmits correctly.
- Build without GMII_TX_FCS_EN, 10-byte frame: TX_EN is high for 18 cycles, with no pad and no FCS.
